// File: rtl/obstacle_move_scheduler_if.sv
// Signal bundle between the move scheduler, button debounce, the rectangle
// array select bus and the pixel generator.
interface obstacle_move_scheduler_if #(
    parameter int SEL_W = 3
);
    logic [3:0]       btns;
    logic [SEL_W-1:0] rect_sel;
    logic             rect_visible;
    logic             blk_up;
    logic             blk_down;
    logic             blk_left;
    logic             blk_right;
    logic [9:0]       player_hPos;
    logic [9:0]       player_vPos;
    logic             step_valid;
    logic [3:0]       step_dir;
    logic             step_denied;
    logic             busy;

    modport master (
        input  btns,
        input  rect_visible,
        input  blk_up,
        input  blk_down,
        input  blk_left,
        input  blk_right,
        output rect_sel,
        output player_hPos,
        output player_vPos,
        output step_valid,
        output step_dir,
        output step_denied,
        output busy
    );

    modport slave (
        output btns,
        output rect_visible,
        output blk_up,
        output blk_down,
        output blk_left,
        output blk_right,
        input  rect_sel,
        input  player_hPos,
        input  player_vPos,
        input  step_valid,
        input  step_dir,
        input  step_denied,
        input  busy
    );
endinterface

// File: rtl/obstacle_move_scheduler.sv
// Player move scheduler: scans every rectangle for a blocker in the pressed
// direction, adds screen-edge limits, then grants or denies one step per press.
module obstacle_move_scheduler #(
    parameter int NUM_RECT = 8,
    parameter int SEL_W    = 3,
    parameter int PW       = 12,
    parameter int PH       = 12,
    parameter int H_MAX    = 640,
    parameter int V_MAX    = 480,
    parameter int REPEAT   = 16,
    parameter int H_INIT   = 0,
    parameter int V_INIT   = 0
) (
    input  logic                      btnClk,
    input  logic                      rst,
    obstacle_move_scheduler_if.master bus
);

    localparam logic [3:0] DIR_U = 4'b1000;
    localparam logic [3:0] DIR_D = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_L = 4'b0001;

    localparam int              RPT_W    = $clog2(REPEAT + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_RECT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] rect_sel_q, rect_sel_d;
    logic             blk_acc_q, blk_acc_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [3:0]       dir_q, dir_d;
    logic             step_valid_q, step_valid_d;
    logic             step_denied_q, step_denied_d;
    logic [3:0]       step_dir_q, step_dir_d;
    logic             busy_q, busy_d;
    logic [9:0]       hpos_q, hpos_d;
    logic [9:0]       vpos_q, vpos_d;

    logic             btn_onehot;
    logic             rect_blk;
    logic             edge_blk;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;

    // One pixel step that never wraps past either end of the 10-bit range.
    function automatic logic [9:0] step_pos(input logic [9:0] pos,
                                            input logic       inc,
                                            input logic       dec);
        logic [9:0] res;
        res = pos;
        if (inc && (pos != 10'h3FF)) begin
            res = pos + 10'd1;
        end else if (dec && (pos != 10'd0)) begin
            res = pos - 10'd1;
        end
        return res;
    endfunction

    assign btn_onehot = (bus.btns == DIR_U) || (bus.btns == DIR_D) ||
                        (bus.btns == DIR_R) || (bus.btns == DIR_L);

    assign rect_blk = bus.rect_visible &
                      ((dir_q[3] & bus.blk_up)    | (dir_q[2] & bus.blk_down) |
                       (dir_q[1] & bus.blk_right) | (dir_q[0] & bus.blk_left));

    // Far-edge sums are formed in 11 bits so hPos+PW cannot wrap.
    assign h_ext = {1'b0, hpos_q} + 11'(PW);
    assign v_ext = {1'b0, vpos_q} + 11'(PH);

    assign edge_blk = (dir_q[3] & (vpos_q == 10'd0))        |
                      (dir_q[2] & (v_ext >= 11'(V_MAX)))     |
                      (dir_q[0] & (hpos_q == 10'd0))         |
                      (dir_q[1] & (h_ext >= 11'(H_MAX)));

    always_comb begin
        state_d       = state_q;
        rect_sel_d    = rect_sel_q;
        blk_acc_d     = blk_acc_q;
        rpt_cnt_d     = rpt_cnt_q;
        dir_d         = dir_q;
        step_valid_d  = 1'b0;
        step_denied_d = 1'b0;
        step_dir_d    = step_dir_q;
        busy_d        = busy_q;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;

        case (state_q)
            IDLE: begin
                if (btn_onehot) begin
                    dir_d      = bus.btns;
                    rect_sel_d = '0;
                    blk_acc_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                blk_acc_d = blk_acc_q | rect_blk;
                if (rect_sel_q == SEL_LAST) begin
                    rect_sel_d = '0;
                    state_d    = DECIDE;
                end else begin
                    rect_sel_d = rect_sel_q + 1'b1;
                end
            end

            DECIDE: begin
                step_dir_d = dir_q;
                busy_d     = 1'b0;
                rpt_cnt_d  = '0;
                state_d    = HOLD;
                if (blk_acc_q || edge_blk) begin
                    step_denied_d = 1'b1;
                end else begin
                    step_valid_d = 1'b1;
                    hpos_d = step_pos(hpos_q, dir_q[1], dir_q[0]);
                    vpos_d = step_pos(vpos_q, dir_q[2], dir_q[3]);
                end
            end

            HOLD: begin
                if (bus.btns != dir_q) begin
                    state_d = IDLE;
                end else if (rpt_cnt_q == RPT_LAST) begin
                    rect_sel_d = '0;
                    blk_acc_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rect_sel_q    <= '0;
            blk_acc_q     <= 1'b0;
            rpt_cnt_q     <= '0;
            dir_q         <= 4'b0000;
            step_valid_q  <= 1'b0;
            step_denied_q <= 1'b0;
            step_dir_q    <= 4'b0000;
            busy_q        <= 1'b0;
            hpos_q        <= 10'(H_INIT);
            vpos_q        <= 10'(V_INIT);
        end else begin
            state_q       <= state_d;
            rect_sel_q    <= rect_sel_d;
            blk_acc_q     <= blk_acc_d;
            rpt_cnt_q     <= rpt_cnt_d;
            dir_q         <= dir_d;
            step_valid_q  <= step_valid_d;
            step_denied_q <= step_denied_d;
            step_dir_q    <= step_dir_d;
            busy_q        <= busy_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
        end
    end

    assign bus.rect_sel    = rect_sel_q;
    assign bus.player_hPos = hpos_q;
    assign bus.player_vPos = vpos_q;
    assign bus.step_valid  = step_valid_q;
    assign bus.step_denied = step_denied_q;
    assign bus.step_dir    = step_dir_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_obstacle_move_scheduler.sv
// Bench for obstacle_move_scheduler: directed scenarios plus randomized presses
// against a timeline model of press -> scan -> decide -> hold/repeat.
module tb_obstacle_move_scheduler;

    localparam int NUM_RECT = 8;
    localparam int SEL_W    = 3;
    localparam int PW       = 12;
    localparam int PH       = 12;
    localparam int H_MAX    = 640;
    localparam int V_MAX    = 480;
    localparam int REPEAT   = 16;
    localparam int H_INIT   = 620;
    localparam int V_INIT   = 0;

    logic btnClk = 1'b0;
    logic rst    = 1'b1;

    obstacle_move_scheduler_if #(.SEL_W(SEL_W)) bus ();

    obstacle_move_scheduler #(
        .NUM_RECT(NUM_RECT), .SEL_W(SEL_W), .PW(PW), .PH(PH),
        .H_MAX(H_MAX), .V_MAX(V_MAX), .REPEAT(REPEAT),
        .H_INIT(H_INIT), .V_INIT(V_INIT)
    ) dut (
        .btnClk(btnClk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 btnClk = ~btnClk;

    // Rectangle array seen through the select bus; rblk bits use btns encoding.
    logic [NUM_RECT-1:0] vis;
    logic [3:0]          rblk [NUM_RECT];

    assign bus.rect_visible = vis[bus.rect_sel];
    assign bus.blk_up       = rblk[bus.rect_sel][3];
    assign bus.blk_down     = rblk[bus.rect_sel][2];
    assign bus.blk_right    = rblk[bus.rect_sel][1];
    assign bus.blk_left     = rblk[bus.rect_sel][0];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Model: busy_left counts the busy cycles still to come (scan + decide),
    // hold_age counts cycles since the decision while the button stays held.
    int         m_busy_left = 0;
    int         m_hold_age  = -1;
    int         m_h         = H_INIT;
    int         m_v         = V_INIT;
    logic [3:0] m_dir       = 4'b0000;
    logic [3:0] m_sdir      = 4'b0000;
    bit         m_valid     = 1'b0;
    bit         m_denied    = 1'b0;

    function automatic bit model_blocked(input logic [3:0] d, input int h, input int v);
        bit b;
        b = 1'b0;
        for (int i = 0; i < NUM_RECT; i++)
            if (vis[i] && ((rblk[i] & d) != 4'b0000)) b = 1'b1;
        if (d == 4'b1000 && v == 0)           b = 1'b1;
        if (d == 4'b0100 && v + PH >= V_MAX)  b = 1'b1;
        if (d == 4'b0001 && h == 0)           b = 1'b1;
        if (d == 4'b0010 && h + PW >= H_MAX)  b = 1'b1;
        return b;
    endfunction

    initial forever begin
        @(posedge btnClk or posedge rst);
        if (rst) begin
            m_busy_left = 0; m_hold_age = -1; m_h = H_INIT; m_v = V_INIT;
            m_dir = 4'b0000; m_sdir = 4'b0000; m_valid = 1'b0; m_denied = 1'b0;
        end else begin
            m_valid  = 1'b0;
            m_denied = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_sdir     = m_dir;
                    m_hold_age = 0;
                    if (model_blocked(m_dir, m_h, m_v)) begin
                        m_denied = 1'b1;
                    end else begin
                        m_valid = 1'b1;
                        case (m_dir)
                            4'b1000: m_v = m_v - 1;
                            4'b0100: m_v = m_v + 1;
                            4'b0010: m_h = m_h + 1;
                            default: m_h = m_h - 1;
                        endcase
                    end
                end
            end else if (m_hold_age >= 0) begin
                if (bus.btns != m_dir) m_hold_age = -1;
                else if (m_hold_age == REPEAT - 1) begin
                    m_hold_age  = -1;
                    m_busy_left = NUM_RECT + 1;
                end else m_hold_age++;
            end else if ($countones(bus.btns) == 1) begin
                m_dir       = bus.btns;
                m_busy_left = NUM_RECT + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge btnClk);
        if (!rst) begin
            chk("step_valid",  bus.step_valid,  m_valid);
            chk("step_denied", bus.step_denied, m_denied);
            chk("step_dir",    bus.step_dir,    m_sdir);
            chk("busy",        bus.busy,        m_busy_left > 0);
            chk("rect_sel",    bus.rect_sel,    (m_busy_left >= 2) ? NUM_RECT + 1 - m_busy_left : 0);
            chk("hPos",        bus.player_hPos, m_h);
            chk("vPos",        bus.player_vPos, m_v);
            chk("valid_and_denied", bus.step_valid & bus.step_denied, 0);
        end
    end

    // One sampling edge of b, then released; cycle k is the k-th cycle after that edge.
    task automatic tap(input logic [3:0] b, output int v_cyc, output int d_cyc,
                       output logic [15:0] bmask);
        v_cyc = -1; d_cyc = -1; bmask = '0;
        @(negedge btnClk); bus.btns = b;
        @(negedge btnClk); bus.btns = 4'b0000;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge btnClk);
            bmask[k] = bus.busy;
            if (bus.step_valid)  v_cyc = k;
            if (bus.step_denied) d_cyc = k;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int          vc, dc, den, sd, nrun;
        logic [15:0] bm;
        int          pulses[$];
        bit          any_busy, any_pulse;

        bus.btns = 4'b0000;
        vis = '0;
        for (int i = 0; i < NUM_RECT; i++) rblk[i] = 4'b0000;

        repeat (2) @(negedge btnClk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rect_sel", bus.rect_sel, 0);
        chk("rst_valid", bus.step_valid, 0);
        chk("rst_denied", bus.step_denied, 0);
        chk("rst_step_dir", bus.step_dir, 0);
        chk("rst_hPos", bus.player_hPos, 620);
        chk("rst_vPos", bus.player_vPos, 0);
        rst = 1'b0;

        // Up at the top edge is refused.
        tap(4'b1000, vc, dc, bm);
        chk("up_edge_denied_cycle", dc, 10);
        chk("up_edge_no_grant", vc, -1);
        chk("up_edge_vPos", bus.player_vPos, 0);

        // Single down press, empty array.
        tap(4'b0100, vc, dc, bm);
        chk("down_grant_cycle", vc, 10);
        chk("down_no_deny", dc, -1);
        chk("down_busy_cycles", bm, 16'h03FE);
        chk("down_step_dir", bus.step_dir, 4'b0100);
        chk("down_vPos", bus.player_vPos, 1);

        // Visible blocker in slot 5, then the same slot made invisible.
        vis[5] = 1'b1; rblk[5] = 4'b0100;
        tap(4'b0100, vc, dc, bm);
        chk("blk5_denied_cycle", dc, 10);
        chk("blk5_no_grant", vc, -1);
        chk("blk5_vPos", bus.player_vPos, 1);
        vis[5] = 1'b0;
        tap(4'b0100, vc, dc, bm);
        chk("hidden5_grant_cycle", vc, 10);
        chk("hidden5_vPos", bus.player_vPos, 2);

        // Hold right from 620: eight grants 25 cycles apart, then the edge refuses.
        @(negedge btnClk); bus.btns = 4'b0010;
        den = -1;
        for (int k = 1; k <= 300 && den < 0; k++) begin
            @(negedge btnClk);
            if (bus.step_valid)  pulses.push_back(k);
            if (bus.step_denied) den = k;
        end
        bus.btns = 4'b0000;
        chk("repeat_grant_count", pulses.size(), 8);
        if (pulses.size() > 0) chk("repeat_first_grant", pulses[0], 10);
        for (int i = 1; i < pulses.size(); i++)
            chk("repeat_period", pulses[i] - pulses[i-1], 25);
        chk("repeat_edge_denied_cycle", den, 210);
        chk("repeat_hPos", bus.player_hPos, 628);
        repeat (3) @(negedge btnClk);

        tap(4'b0010, vc, dc, bm);
        chk("right_edge_denied_cycle", dc, 10);
        chk("right_edge_hPos", bus.player_hPos, 628);

        // Walk left all the way to the left edge.
        for (int i = 0; i < 628; i++) tap(4'b0001, vc, dc, bm);
        chk("left_walk_hPos", bus.player_hPos, 0);
        tap(4'b0001, vc, dc, bm);
        chk("left_edge_denied_cycle", dc, 10);
        chk("left_edge_hPos", bus.player_hPos, 0);

        // Multi-hot and zero buttons are ignored.
        any_busy = 1'b0; any_pulse = 1'b0;
        @(negedge btnClk); bus.btns = 4'b1010;
        repeat (30) begin
            @(negedge btnClk);
            any_busy  |= bus.busy;
            any_pulse |= bus.step_valid | bus.step_denied;
        end
        bus.btns = 4'b0000;
        repeat (30) begin
            @(negedge btnClk);
            any_busy  |= bus.busy;
            any_pulse |= bus.step_valid | bus.step_denied;
        end
        chk("multihot_busy", any_busy, 0);
        chk("multihot_pulse", any_pulse, 0);

        // Button changes during the scan do not alter the decision.
        @(negedge btnClk); bus.btns = 4'b1000;
        vc = -1; sd = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge btnClk);
            if (k == 3) bus.btns = 4'b0100;
            if (bus.step_valid) begin vc = k; sd = int'(bus.step_dir); end
            if (k == 10) bus.btns = 4'b0000;
        end
        chk("switch_grant_cycle", vc, 10);
        chk("switch_step_dir", sd, 8);
        chk("switch_vPos", bus.player_vPos, 1);
        repeat (4) @(negedge btnClk);

        // Reset in the middle of a scan.
        @(negedge btnClk); bus.btns = 4'b0100;
        @(negedge btnClk); bus.btns = 4'b0000;
        repeat (4) @(negedge btnClk);
        chk("midscan_rect_sel", bus.rect_sel, 4);
        #1 rst = 1'b1;
        @(negedge btnClk);
        chk("midscan_rst_busy", bus.busy, 0);
        chk("midscan_rst_rect_sel", bus.rect_sel, 0);
        chk("midscan_rst_valid", bus.step_valid, 0);
        chk("midscan_rst_denied", bus.step_denied, 0);
        chk("midscan_rst_step_dir", bus.step_dir, 0);
        chk("midscan_rst_hPos", bus.player_hPos, 620);
        chk("midscan_rst_vPos", bus.player_vPos, 0);
        rst = 1'b0;
        tap(4'b0100, vc, dc, bm);
        chk("after_rst_grant_cycle", vc, 10);
        chk("after_rst_busy_cycles", bm, 16'h03FE);
        chk("after_rst_vPos", bus.player_vPos, 1);

        // Randomized presses, holds and direction changes over random arrays.
        for (int it = 0; it < 150; it++) begin
            bus.btns = 4'b0000;
            for (int w = 0; w < 40 && !(m_busy_left == 0 && m_hold_age < 0); w++)
                @(negedge btnClk);
            chk("rand_idle_busy", bus.busy, 0);
            for (int i = 0; i < NUM_RECT; i++) begin
                vis[i]  = ($urandom_range(0, 7) == 0);
                rblk[i] = 4'($urandom);
            end
            nrun = $urandom_range(1, 70);
            for (int c = 0; c < nrun; c++) begin
                if (c == 0 || $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 9) < 7) bus.btns = 4'b0001 << $urandom_range(0, 3);
                    else                          bus.btns = 4'($urandom);
                end
                @(negedge btnClk);
            end
        end
        bus.btns = 4'b0000;
        repeat (12) @(negedge btnClk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
